// File: rtl/serial_word_receiver.sv
// UART-style word receiver: start bit, WORD_SIZE data bits LSB first, stop bit.
// Define SERIAL_RX_PARITY_EN to expect an even parity bit between data and stop.
module serial_word_receiver #(
  parameter int WORD_SIZE    = 4,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [6:0]           hex
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [WORD_SIZE-1:0] shift, shift_n;
  logic [WORD_SIZE-1:0] data_n;
  logic [6:0]           hex_n;
  logic                 valid_n, ferr_n, busy_n;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [1:0]           sync_live;
  logic                 start_edge;
  logic                 parity_good;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // sync_live marks when rx_sync holds a real line sample rather than its reset
  // value, so a line held low through reset never looks like a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b0;
      sync_live <= '0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      sync_live <= {sync_live[0], 1'b1};
      rx_prev   <= sync_live[1] ? rx_sync : 1'b0;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

`ifdef SERIAL_RX_PARITY_EN
  logic par_ok, par_ok_n;

  always_ff @(posedge clock) begin
    if (reset) par_ok <= 1'b0;
    else       par_ok <= par_ok_n;
  end

  assign parity_good = par_ok;
`else
  assign parity_good = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = data_out;
    hex_n   = hex;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_ok_n = par_ok;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n                = '0;
          shift_n              = shift >> 1;
          shift_n[WORD_SIZE-1] = rx_sync;
          bit_n                = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          par_ok_n = ~(^shift ^ rx_sync);
          state_n  = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_sync) begin
            state_n = IDLE;
            if (parity_good) begin
              valid_n = 1'b1;
              data_n  = shift;
              hex_n   = seg7(4'(shift));
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= '0;
      hex         <= 7'b1111111;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_n;
      shift       <= shift_n;
      data_out    <= data_n;
      hex         <= hex_n;
      valid       <= valid_n;
      frame_error <= ferr_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: stimulus pushes expected words,
// a negedge monitor pops one entry per valid/frame_error pulse.
module tb_serial_word_receiver;

  localparam int W   = 4;
  localparam int CPB = 10;
  localparam int H   = CPB / 2;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         rx;
  logic [W-1:0] data_out;
  logic         valid;
  logic         frame_error;
  logic         busy;
  logic [6:0]   hex;

  serial_word_receiver #(.WORD_SIZE(W), .CLKS_PER_BIT(CPB)) dut (
    .clock      (CLOCK_50),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy),
    .hex        (hex)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       err;
    logic [3:0] data;
    logic [6:0] hex;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] last_good;
  logic [6:0] last_hex;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_good(input logic [3:0] w);
    exp_t e;
    last_good = w;
    last_hex  = seg_ref(w);
    e = '{err: 1'b0, data: w, hex: last_hex};
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e = '{err: 1'b1, data: last_good, hex: last_hex};
    sb.push_back(e);
  endtask

  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (reset === 1'b0 && (valid !== 1'b0 || frame_error !== 1'b0)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b frame_error=%0b, required none",
                 valid, frame_error);
      end else begin
        e = sb.pop_front();
        check("pulse_frame_error", frame_error, e.err);
        check("pulse_valid", valid, !e.err);
        check("pulse_data_out", data_out, e.data);
        check("pulse_hex", hex, e.hex);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic bit_time(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [3:0] w, input logic stop_val, input int stop_len,
                      input logic par_flip, input bit chk_busy);
    rx = 1'b0;
    for (int k = 0; k < CPB; k++) begin
      @(negedge CLOCK_50);
      if (chk_busy && k < 4) check("busy_rise", busy, (k >= 2));
    end
    for (int i = 0; i < W; i++) bit_time(w[i], CPB);
`ifdef SERIAL_RX_PARITY_EN
    bit_time(^w ^ par_flip, CPB);
`else
    if (par_flip) bit_time(1'b1, 0);
`endif
    bit_time(stop_val, stop_len);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic busy_seen;
    last_good = 4'h0;
    last_hex  = 7'b1111111;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    idle(50);
    check("reset_data_out", data_out, 4'h0);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_hex", hex, 7'b1111111);

    // single good frame with busy latency check
    expect_good(4'h5);
    send(4'h5, 1'b1, CPB, 1'b0, 1'b1);
    idle(2 * CPB);
    check("f5_data_out", data_out, 4'h5);
    check("f5_hex", hex, 7'b0010010);
    check("f5_busy_after", busy, 1'b0);

    // stop bit low, then recovery
    expect_err();
    send(4'hA, 1'b0, CPB, 1'b0, 1'b0);
    idle(2 * CPB);
    check("ferr_data_kept", data_out, 4'h5);
    check("ferr_hex_kept", hex, 7'b0010010);
    expect_good(4'h3);
    send(4'h3, 1'b1, CPB, 1'b0, 1'b0);
    idle(2 * CPB);
    check("f3_hex", hex, 7'b0110000);

    // short low glitch on idle line
    bit_time(1'b0, 3);
    idle(3 * CPB);
    check("glitch_data_kept", data_out, 4'h3);
    check("glitch_busy", busy, 1'b0);

    // back-to-back, first stop just over half a bit
    expect_good(4'hF);
    expect_good(4'h0);
    send(4'hF, 1'b1, H + 1, 1'b0, 1'b0);
    send(4'h0, 1'b1, CPB, 1'b0, 1'b0);
    idle(2 * CPB);
    check("b2b_data_out", data_out, 4'h0);
    check("b2b_hex", hex, 7'b1000000);

    // reset mid-data, then line held low
    bit_time(1'b0, CPB);
    bit_time(1'b1, CPB);
    bit_time(1'b1, 3);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset     = 1'b0;
    last_good = 4'h0;
    last_hex  = 7'b1111111;
    rx        = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge CLOCK_50);
      busy_seen = busy_seen | busy;
    end
    check("low_after_reset_busy", busy_seen, 1'b0);
    check("low_after_reset_data", data_out, 4'h0);
    check("low_after_reset_hex", hex, 7'b1111111);
    idle(CPB);
    expect_good(4'h9);
    send(4'h9, 1'b1, CPB, 1'b0, 1'b0);
    idle(2 * CPB);
    check("f9_data_out", data_out, 4'h9);
    check("f9_hex", hex, 7'b0010000);

`ifdef SERIAL_RX_PARITY_EN
    expect_err();
    send(4'h7, 1'b1, CPB, 1'b1, 1'b0);
    idle(2 * CPB);
    check("parity_data_kept", data_out, 4'h9);
    check("parity_busy", busy, 1'b0);
`endif

    idle(CPB);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
